fir_mac_sequencer: RTL and testbench

Sequential multiply-accumulate controller for the 8-bit FIR datapath. Holds the sample delay line and coefficient bank, and computes y[n] = sum(c[i]*x[n-i]) by shift-and-add. All additions go through the existing 8-bit combinational ALU: the sequencer drives the ALU operands and opcode, then registers its result and carry. The block sits directly upstream of the ALU and also consumes the ALU's outputs.

---
 rtl/fir_mac_pkg.sv | 19 +
 rtl/fir_delay_line.sv | 43 ++++
 rtl/fir_mac_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_mac_pkg.sv
// Shared widths, ALU opcodes and sequencer state encoding for the FIR MAC datapath.
package fir_mac_pkg;

    localparam int unsigned SAMPLE_W = 8;
    localparam int unsigned COEF_W   = 8;
    localparam int unsigned ACC_W    = 16;

    localparam logic [3:0] ALU_OP_ADD = 4'd0;
    localparam logic [3:0] ALU_OP_ADC = 4'd1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        ADD_LO = 3'd2,
        ADD_HI = 3'd3,
        DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/fir_delay_line.sv
// Sample delay line: TAPS x SAMPLE_W shift register with an indexed combinational read port.
module fir_delay_line
    import fir_mac_pkg::*;
#(
    parameter int unsigned TAPS  = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                shift_en,
    input  logic [SAMPLE_W-1:0] din,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [SAMPLE_W-1:0] rd_data_c
);

    logic [SAMPLE_W-1:0] x_q [TAPS];
    logic [SAMPLE_W-1:0] x_d [TAPS];

    // Newest sample enters at x[0]; the oldest falls off the end.
    always_comb begin
        x_d = x_q;
        if (shift_en) begin
            x_d[0] = din;
            for (int i = 1; i < int'(TAPS); i++) begin
                x_d[i] = x_q[i-1];
            end
        end
    end

    // Delay line storage, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(TAPS); i++) begin
                x_q[i] <= '0;
            end
        end else begin
            x_q <= x_d;
        end
    end

    assign rd_data_c = (32'(rd_idx) < TAPS) ? x_q[rd_idx] : '0;

endmodule

// File: rtl/fir_mac_sequencer.sv
// Shift-and-add FIR MAC sequencer driving an external 8-bit ALU, two bytes per partial product.
// Optional macro FIR_MAC_SAT_EN: saturate out_data to 16'hFFFF when the accumulation overflowed.
module fir_mac_sequencer
    import fir_mac_pkg::*;
#(
    parameter int unsigned TAPS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] in_data,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W-1:0]    out_data,
    output logic                out_ovf,
    input  logic                coef_we,
    input  logic [2:0]          coef_addr,
    input  logic [COEF_W-1:0]   coef_data,
    output logic [7:0]          alu_a,
    output logic [7:0]          alu_b,
    output logic [3:0]          alu_op,
    output logic                alu_cin,
    input  logic [7:0]          alu_out,
    input  logic                alu_cout
);

    localparam int unsigned TAP_W = $clog2(TAPS);

    state_e              state_q, state_d;
    logic [COEF_W-1:0]   coef_q [TAPS];
    logic [COEF_W-1:0]   coef_d [TAPS];
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    prod_q, prod_d;
    logic [TAP_W-1:0]    tap_idx_q, tap_idx_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic                carry_q, carry_d;
    logic                ovf_q, ovf_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [ACC_W-1:0]    out_data_q, out_data_d;
    logic                out_ovf_q, out_ovf_d;
    logic [7:0]          alu_a_q, alu_a_d;
    logic [7:0]          alu_b_q, alu_b_d;
    logic [3:0]          alu_op_q, alu_op_d;
    logic                alu_cin_q, alu_cin_d;
    logic [SAMPLE_W-1:0] next_x_c;

    fir_delay_line #(
        .TAPS  (TAPS),
        .IDX_W (TAP_W)
    ) u_delay_line (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift_en  (state_q == LOAD),
        .din       (sample_q),
        .rd_idx    (tap_idx_q + TAP_W'(1)),
        .rd_data_c (next_x_c)
    );

    // Next-state, datapath update, and ALU drive computed from the upcoming state so alu_* is registered.
    always_comb begin
        state_d     = state_q;
        coef_d      = coef_q;
        sample_d    = sample_q;
        acc_d       = acc_q;
        prod_d      = prod_q;
        tap_idx_d   = tap_idx_q;
        bit_idx_d   = bit_idx_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        alu_a_d     = 8'h00;
        alu_b_d     = 8'h00;
        alu_op_d    = ALU_OP_ADD;
        alu_cin_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (coef_we && (32'(coef_addr) < TAPS)) begin
                    coef_d[TAP_W'(coef_addr)] = coef_data;
                end
                if (in_valid && in_ready_q) begin
                    sample_d = in_data;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                acc_d     = '0;
                prod_d    = {8'h00, sample_q};
                tap_idx_d = '0;
                bit_idx_d = '0;
                carry_d   = 1'b0;
                ovf_d     = 1'b0;
                state_d   = ADD_LO;
            end
            ADD_LO: begin
                acc_d[7:0] = alu_out;
                carry_d    = alu_cout;
                state_d    = ADD_HI;
            end
            ADD_HI: begin
                acc_d[15:8] = alu_out;
                ovf_d       = ovf_q | alu_cout;
                if (bit_idx_q < 3'd7) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    prod_d    = prod_q << 1;
                    state_d   = ADD_LO;
                end else if (32'(tap_idx_q) < TAPS - 1) begin
                    tap_idx_d = tap_idx_q + TAP_W'(1);
                    bit_idx_d = '0;
                    prod_d    = {8'h00, next_x_c};
                    state_d   = ADD_LO;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
`ifdef FIR_MAC_SAT_EN
                out_data_d = ovf_q ? 16'hFFFF : acc_q;
`else
                out_data_d = acc_q;
`endif
                out_ovf_d   = ovf_q;
                out_valid_d = 1'b1;
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);

        case (state_d)
            ADD_LO: begin
                alu_a_d   = acc_d[7:0];
                alu_b_d   = coef_d[tap_idx_d][bit_idx_d] ? prod_d[7:0] : 8'h00;
                alu_op_d  = ALU_OP_ADD;
                alu_cin_d = 1'b0;
            end
            ADD_HI: begin
                alu_a_d   = acc_d[15:8];
                alu_b_d   = coef_d[tap_idx_d][bit_idx_d] ? prod_d[15:8] : 8'h00;
                alu_op_d  = ALU_OP_ADC;
                alu_cin_d = carry_d;
            end
            default: ;
        endcase
    end

    // State and datapath registers; reset abandons any computation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            for (int i = 0; i < int'(TAPS); i++) begin
                coef_q[i] <= '0;
            end
            sample_q    <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            tap_idx_q   <= '0;
            bit_idx_q   <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            alu_a_q     <= 8'h00;
            alu_b_q     <= 8'h00;
            alu_op_q    <= ALU_OP_ADD;
            alu_cin_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            coef_q      <= coef_d;
            sample_q    <= sample_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            tap_idx_q   <= tap_idx_d;
            bit_idx_q   <= bit_idx_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            alu_cin_q   <= alu_cin_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign alu_cin   = alu_cin_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench for fir_mac_sequencer with a behavioural 8-bit ALU and a reference FIR model.
module tb_fir_mac_sequencer;
    import fir_mac_pkg::*;

    localparam int unsigned TAPS = 4;
    localparam int unsigned LAT  = 2 + 16 * TAPS;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_ovf;
    logic        coef_we;
    logic [2:0]  coef_addr;
    logic [7:0]  coef_data;
    logic [7:0]  alu_a, alu_b, alu_out;
    logic [3:0]  alu_op;
    logic        alu_cin, alu_cout;

    fir_mac_sequencer #(.TAPS(TAPS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_cin   (alu_cin),
        .alu_out   (alu_out),
        .alu_cout  (alu_cout)
    );

    always #5 clk = ~clk;

    // External ALU: add, or add-with-carry for opcode 1.
    always_comb begin
        {alu_cout, alu_out} = 9'(alu_a) + 9'(alu_b) + 9'((alu_op == ALU_OP_ADC) ? alu_cin : 1'b0);
    end

    typedef struct {
        logic [15:0] data;
        logic        ovf;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    exp_t        last;
    logic [7:0]  m_coef [TAPS];
    logic [7:0]  m_x    [TAPS];
    int unsigned cyc = 0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic        ov_prev = 1'b0;
    logic        saw_cin = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor: compare each new result against the scoreboard head, including latency.
    always @(negedge clk) begin
        if (rst_n && alu_op == ALU_OP_ADC && alu_cin) saw_cin = 1'b1;
        if (out_valid && !ov_prev) begin
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                last = sb.pop_front();
                check("out_data", 32'(out_data), 32'(last.data));
                check("out_ovf", 32'(out_ovf), 32'(last.ovf));
                check("latency", cyc, last.due);
            end
        end
        ov_prev = out_valid;
    end

    task automatic model_clear();
        for (int i = 0; i < int'(TAPS); i++) begin
            m_coef[i] = 8'h00;
            m_x[i]    = 8'h00;
        end
        sb.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_coef(input logic [2:0] addr, input logic [7:0] data);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = addr;
        coef_data = data;
        @(posedge clk);
        #1 coef_we = 1'b0;
        if (32'(addr) < TAPS) m_coef[addr[1:0]] = data;
    endtask

    task automatic send(input logic [7:0] s);
        int unsigned k;
        logic [31:0] sum;
        exp_t        e;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        if (in_ready) begin
            in_valid = 1'b1;
            in_data  = s;
            @(posedge clk);
            #1 in_valid = 1'b0;
            for (int i = int'(TAPS) - 1; i > 0; i--) m_x[i] = m_x[i-1];
            m_x[0] = s;
            sum = 32'd0;
            for (int i = 0; i < int'(TAPS); i++) sum += 32'(m_coef[i]) * 32'(m_x[i]);
            e.ovf  = (sum > 32'h0000_FFFF);
            e.data = sum[15:0];
`ifdef FIR_MAC_SAT_EN
            if (e.ovf) e.data = 16'hFFFF;
`endif
            e.due = cyc + LAT;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int unsigned k;
        k = 0;
        while (sb.size() != 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_out_ovf"}, 32'(out_ovf), 32'd0);
        check({tag, "_alu_a"}, 32'(alu_a), 32'd0);
        check({tag, "_alu_b"}, 32'(alu_b), 32'd0);
        check({tag, "_alu_op"}, 32'(alu_op), 32'd0);
        check({tag, "_alu_cin"}, 32'(alu_cin), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        coef_we   = 1'b0;
        coef_addr = 3'd0;
        coef_data = 8'h00;
        model_clear();

        // Reset and idle state
        repeat (3) @(negedge clk);
        check_idle_outputs("rst_hold");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("rst_release");

        // Basic filter, plus an out-of-range coefficient write that must not alias tap 0
        set_coef(3'd0, 8'd1);
        set_coef(3'd1, 8'd2);
        set_coef(3'd2, 8'd3);
        set_coef(3'd3, 8'd4);
        set_coef(3'd4, 8'd77);
        send(8'd10); drain();
        send(8'd20); drain();
        send(8'd30); drain();
        send(8'd40); drain();

        // Overflow with all-255 coefficients and samples
        do_reset();
        for (int i = 0; i < int'(TAPS); i++) set_coef(3'(i), 8'd255);
        for (int i = 0; i < 4; i++) begin
            send(8'd255);
            drain();
        end

        // Back-pressure and coefficient lockout while busy
        do_reset();
        set_coef(3'd0, 8'd3);
        set_coef(3'd1, 8'd1);
        set_coef(3'd2, 8'd4);
        set_coef(3'd3, 8'd1);
        send(8'd7); drain();
        out_ready = 1'b0;
        send(8'd9); drain();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 5) begin
                coef_we   = 1'b1;
                coef_addr = 3'd0;
                coef_data = 8'd9;
                in_valid  = 1'b1;
                in_data   = 8'd99;
            end else begin
                coef_we  = 1'b0;
                in_valid = 1'b0;
            end
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_data", 32'(out_data), 32'(last.data));
        end
        coef_we   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send(8'd11); drain();

        // Asynchronous reset in the middle of a computation
        send(8'd200);
        repeat (30) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("async_rst");
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'd5); drain();

        // Low-byte carry propagating into the high-byte add
        set_coef(3'd0, 8'd2);
        set_coef(3'd1, 8'd1);
        send(8'h80); drain();
        saw_cin = 1'b0;
        send(8'hFF); drain();
        check("alu_cin_seen", 32'(saw_cin), 32'd1);
        check("carry_result", 32'(last.data), 32'h0000_027E);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
